// File: rtl/conv_col_feeder_if.sv
// Feeder-side bus for conv_col_feeder: sample memory read port plus the
// shift-register column feed and the window valid/ready handshake.
interface conv_col_feeder_if #(
    parameter int ADDR_W = 8
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              shift_en;
    logic [15:0]       col_out;
    logic              sample_valid;
    logic              sample_ready;
    logic [4:0]        win_row;
    logic [4:0]        win_col;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output shift_en,
        output col_out,
        output sample_valid,
        input  sample_ready,
        output win_row,
        output win_col
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  shift_en,
        input  col_out,
        input  sample_valid,
        output sample_ready,
        input  win_row,
        input  win_col
    );
endinterface

// File: rtl/conv_col_feeder.sv
// Raster-walks a 3-row window over a 4-bit image, feeding packed columns into the
// sample shift register. Optional window counter: define CONV_COL_FEEDER_CNT_EN.
module conv_col_feeder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [4:0]        img_width,
    input  logic [4:0]        img_height,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
`ifdef CONV_COL_FEEDER_CNT_EN
    output logic [15:0]       sample_count,
`endif
    conv_col_feeder_if.master bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RD0   = 3'd1;
    localparam logic [2:0] RD1   = 3'd2;
    localparam logic [2:0] RD2   = 3'd3;
    localparam logic [2:0] CAP   = 3'd4;
    localparam logic [2:0] SHIFT = 3'd5;
    localparam logic [2:0] HOLD  = 3'd6;
    localparam logic [2:0] DONE  = 3'd7;

    // Address math is carried wide enough for row*width before wrapping to ADDR_W.
    localparam int AW = (ADDR_W > 10) ? ADDR_W : 10;

    logic [2:0]        state_reg, state_next;
    logic [4:0]        row_reg, row_next;
    logic [4:0]        col_reg, col_next;
    logic [4:0]        width_reg, width_next;
    logic [4:0]        height_reg, height_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [3:0]        pix0_reg, pix0_next;
    logic [3:0]        pix1_reg, pix1_next;
    logic [15:0]       col_word_reg, col_word_next;
    logic [4:0]        win_row_reg, win_row_next;
    logic [4:0]        win_col_reg, win_col_next;

    logic              dims_legal;
    logic [2:0]        adv_state;
    logic [4:0]        adv_row;
    logic [4:0]        adv_col;
    logic [4:0]        rd_row;
    logic [AW-1:0]     addr_full;
    logic              rd_active;
    logic              handshake;

    assign dims_legal = (img_width  >= 5'd3) && (img_width  <= 5'd16) &&
                        (img_height >= 5'd3) && (img_height <= 5'd16);

    assign rd_active = (state_reg == RD0) || (state_reg == RD1) || (state_reg == RD2);
    assign handshake = (state_reg == HOLD) && bus.sample_ready;

    // Step to the next column, then the next band, then finish the frame.
    always_comb begin
        adv_state = DONE;
        adv_row   = row_reg;
        adv_col   = col_reg;
        if (col_reg < width_reg - 5'd1) begin
            adv_col   = col_reg + 5'd1;
            adv_state = RD0;
        end else if (row_reg < height_reg - 5'd3) begin
            adv_row   = row_reg + 5'd1;
            adv_col   = 5'd0;
            adv_state = RD0;
        end
    end

    always_comb begin
        rd_row = row_reg;
        case (state_reg)
            RD1:     rd_row = row_reg + 5'd1;
            RD2:     rd_row = row_reg + 5'd2;
            default: rd_row = row_reg;
        endcase
    end

    assign addr_full = AW'(base_reg) + AW'(rd_row) * AW'(width_reg) + AW'(col_reg);

    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        width_next    = width_reg;
        height_next   = height_reg;
        base_next     = base_reg;
        pix0_next     = pix0_reg;
        pix1_next     = pix1_reg;
        col_word_next = col_word_reg;
        win_row_next  = win_row_reg;
        win_col_next  = win_col_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (dims_legal) begin
                        width_next  = img_width;
                        height_next = img_height;
                        base_next   = base_addr;
                        row_next    = 5'd0;
                        col_next    = 5'd0;
                        state_next  = RD0;
                    end else begin
                        state_next  = DONE;
                    end
                end
            end
            RD0: state_next = RD1;
            RD1: begin
                pix0_next  = bus.mem_rdata[3:0];
                state_next = RD2;
            end
            RD2: begin
                pix1_next  = bus.mem_rdata[3:0];
                state_next = CAP;
            end
            CAP: begin
                col_word_next = {4'h0, bus.mem_rdata[3:0], pix1_reg, pix0_reg};
                state_next    = SHIFT;
            end
            SHIFT: begin
                // The third column of a band completes the first window of that band.
                if (col_reg >= 5'd2) begin
                    win_row_next = row_reg;
                    win_col_next = col_reg - 5'd2;
                    state_next   = HOLD;
                end else begin
                    row_next   = adv_row;
                    col_next   = adv_col;
                    state_next = adv_state;
                end
            end
            HOLD: begin
                if (bus.sample_ready) begin
                    row_next   = adv_row;
                    col_next   = adv_col;
                    state_next = adv_state;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg    <= IDLE;
            row_reg      <= 5'd0;
            col_reg      <= 5'd0;
            width_reg    <= 5'd0;
            height_reg   <= 5'd0;
            base_reg     <= '0;
            pix0_reg     <= 4'd0;
            pix1_reg     <= 4'd0;
            col_word_reg <= 16'd0;
            win_row_reg  <= 5'd0;
            win_col_reg  <= 5'd0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            width_reg    <= width_next;
            height_reg   <= height_next;
            base_reg     <= base_next;
            pix0_reg     <= pix0_next;
            pix1_reg     <= pix1_next;
            col_word_reg <= col_word_next;
            win_row_reg  <= win_row_next;
            win_col_reg  <= win_col_next;
        end
    end

`ifdef CONV_COL_FEEDER_CNT_EN
    logic [15:0] sample_count_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sample_count_reg <= 16'd0;
        end else if ((state_reg == IDLE) && start && dims_legal) begin
            sample_count_reg <= 16'd0;
        end else if (handshake) begin
            sample_count_reg <= sample_count_reg + 16'd1;
        end
    end

    assign sample_count = sample_count_reg;
`endif

    assign bus.mem_rd_en    = rd_active;
    assign bus.mem_addr     = rd_active ? addr_full[ADDR_W-1:0] : '0;
    assign bus.shift_en     = (state_reg == SHIFT);
    assign bus.col_out      = col_word_reg;
    assign bus.sample_valid = (state_reg == HOLD);
    assign bus.win_row      = win_row_reg;
    assign bus.win_col      = win_col_reg;

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_conv_col_feeder.sv
// Randomized bench for conv_col_feeder: a frame-level model predicts read addresses,
// column words, window positions and handshake timing for each frame.
module tb_conv_col_feeder;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic [4:0]        img_width = 5'd0;
    logic [4:0]        img_height = 5'd0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              busy;
    logic              done;
`ifdef CONV_COL_FEEDER_CNT_EN
    logic [15:0]       sample_count;
`endif

    conv_col_feeder_if #(.ADDR_W(ADDR_W)) bus ();

    conv_col_feeder #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .img_width    (img_width),
        .img_height   (img_height),
        .base_addr    (base_addr),
        .busy         (busy),
        .done         (done),
`ifdef CONV_COL_FEEDER_CNT_EN
        .sample_count (sample_count),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Latency-1 sample memory; junk on the bus when no read is pending.
    logic [15:0] mem [0:255];
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_addr] : 16'($urandom);

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    int          rdy_mode = 0;
    logic [63:0] rdy_pat = '1;

    function automatic logic rdy_at(input int k);
        case (rdy_mode)
            0:       return 1'b1;
            1:       return rdy_pat[k % 64];
            default: return (k >= 21);
        endcase
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_shift"}, bus.shift_en, 0);
        chk({tag, "_col_out"}, bus.col_out, 0);
        chk({tag, "_valid"}, bus.sample_valid, 0);
        chk({tag, "_win_row"}, bus.win_row, 0);
        chk({tag, "_win_col"}, bus.win_col, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic fill_mem(input bit pix_is_addr);
        for (int a = 0; a < 256; a++) begin
            logic [15:0] rv;
            logic [7:0]  av;
            rv = 16'($urandom);
            av = 8'(a);
            mem[a] = pix_is_addr ? {rv[15:4], av[3:0]} : rv;
        end
    endtask

    task automatic run_frame(input int w, input int h, input logic [7:0] base,
                             input int glitch_k, input int abort_k);
        logic [7:0]  exp_rd[$];
        logic [7:0]  got_rd[$];
        logic [15:0] exp_sh[$];
        logic [15:0] got_sh[$];
        logic [9:0]  exp_win[$];
        logic [9:0]  got_win[$];
        logic [7:0]  a [3];
        logic [3:0]  p0, p1, p2;
        bit          legal;
        bit          aborted;
        int          exp_done, exp_valid, exp_first, t, hc;
        int          done_cyc, valid_cyc, first_valid, ovl, busy_low, k, t0;

        legal = (w >= 3) && (w <= 16) && (h >= 3) && (h <= 16);
        exp_done = 1; exp_valid = 0; exp_first = -1;
        if (legal) begin
            t = 1;
            for (int r = 0; r <= h - 3; r++) begin
                for (int c = 0; c < w; c++) begin
                    for (int kk = 0; kk < 3; kk++) begin
                        a[kk] = 8'(int'(base) + (r + kk) * w + c);
                        exp_rd.push_back(a[kk]);
                    end
                    p0 = mem[a[0]][3:0];
                    p1 = mem[a[1]][3:0];
                    p2 = mem[a[2]][3:0];
                    exp_sh.push_back({4'h0, p2, p1, p0});
                    if (c >= 2) begin
                        exp_win.push_back({5'(r), 5'(c - 2)});
                        hc = t + 5;
                        if (exp_first < 0) exp_first = hc;
                        while (!rdy_at(hc)) begin
                            hc++;
                            exp_valid++;
                        end
                        exp_valid++;
                        t = hc + 1;
                    end else begin
                        t = t + 5;
                    end
                end
            end
            exp_done = t;
        end

        done_cyc = -1; valid_cyc = 0; first_valid = -1; ovl = 0; busy_low = 0; aborted = 0;
        @(negedge clk);
        img_width  = 5'(w);
        img_height = 5'(h);
        base_addr  = base;
        start      = 1'b1;
        t0         = cyc;
        @(negedge clk);
        for (int n = 0; n < 5000; n++) begin
            k = cyc - t0;
            bus.sample_ready = rdy_at(k);
            start = (k == glitch_k);
            if (k == abort_k) begin
                n_rst = 1'b0;
                #1;
                chk_all_zero("abort");
                aborted = 1;
                break;
            end
            if (!busy) busy_low++;
            if (bus.sample_valid && (bus.shift_en || bus.mem_rd_en)) ovl++;
            if (bus.mem_rd_en) got_rd.push_back(bus.mem_addr);
            if (bus.shift_en) got_sh.push_back(bus.col_out);
            if (bus.sample_valid) begin
                valid_cyc++;
                if (first_valid < 0) first_valid = k;
                if (bus.sample_ready) got_win.push_back({bus.win_row, bus.win_col});
            end
`ifdef CONV_COL_FEEDER_CNT_EN
            if (k == 1 && legal) chk("cnt_clear", sample_count, 0);
`endif
            if (done) begin
                done_cyc = k;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;

        if (aborted) begin
            repeat (3) begin
                @(negedge clk);
                chk("abort_no_done", done, 0);
                chk("abort_busy", busy, 0);
            end
            n_rst = 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("after_abort_done", done, 0);
                chk("after_abort_busy", busy, 0);
            end
            $display("frame %0dx%0d base=%02h aborted at cycle %0d", w, h, base, abort_k);
            return;
        end

        chk("n_reads", got_rd.size(), exp_rd.size());
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++) chk("rd_addr", got_rd[i], exp_rd[i]);
        chk("n_shifts", got_sh.size(), exp_sh.size());
        for (int i = 0; i < got_sh.size() && i < exp_sh.size(); i++) chk("col_out", got_sh[i], exp_sh[i]);
        chk("n_samples", got_win.size(), exp_win.size());
        for (int i = 0; i < got_win.size() && i < exp_win.size(); i++) chk("win_pos", got_win[i], exp_win[i]);
        chk("first_valid_cyc", first_valid, exp_first);
        chk("valid_cycles", valid_cyc, exp_valid);
        chk("done_cyc", done_cyc, exp_done);
        chk("held_overlap", ovl, 0);
        chk("busy_drop", busy_low, 0);
        $display("frame %0dx%0d base=%02h reads=%0d shifts=%0d samples=%0d done@%0d",
                 w, h, base, got_rd.size(), got_sh.size(), got_win.size(), done_cyc);
        @(negedge clk);
        chk("busy_after_done", busy, 0);
        chk("done_single", done, 0);
`ifdef CONV_COL_FEEDER_CNT_EN
        if (legal) chk("sample_count", sample_count, exp_win.size());
`endif
    endtask

    initial begin
        bus.sample_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        fill_mem(1'b1);
        rdy_mode = 0;
        run_frame(3, 3, 8'h10, -1, -1);

        fill_mem(1'b0);
        run_frame(4, 4, 8'($urandom), -1, -1);

        rdy_mode = 2;
        run_frame(3, 3, 8'($urandom), -1, -1);

        rdy_mode = 0;
        run_frame(2, 5, 8'($urandom), -1, -1);
        run_frame(5, 17, 8'($urandom), -1, -1);

        run_frame(4, 4, 8'($urandom), 7, -1);
        run_frame(4, 4, 8'($urandom), 7, 12);

        run_frame(5, 4, 8'($urandom), -1, -1);

        rdy_mode = 1;
        repeat (6) begin
            fill_mem(1'b0);
            rdy_pat = {32'($urandom), 32'($urandom)} | 64'h0101_0101_0101_0101;
            run_frame(int'($urandom_range(3, 16)), int'($urandom_range(3, 16)),
                      8'($urandom), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_col_feeder.md
# conv_col_feeder

Column feeder for the AHB convolver, on the producer side of the sample shift register's `shift_en`/`col_in` interface. It raster-walks a 3-row window across a 4-bit-per-pixel image held in a one-pixel-per-word, latency-1 sample memory. For each window column it issues three reads and packs the results into one 16-bit column word, presented with a single-cycle `shift_en`. Once the shift register holds three columns of the current band, it raises `sample_valid` and holds it under a ready handshake.

## Interface
- `ADDR_W`, default 8: memory address width. Address arithmetic wraps modulo 2^ADDR_W.
- `clk` in 1: clock, rising edge.
- `n_rst` in 1: reset, asynchronous, active-low.
- `start` in 1: sampled only in IDLE; begins a frame.
- `img_width` in 5: image columns. Legal range 3..16. Sampled at start.
- `img_height` in 5: image rows. Legal range 3..16. Sampled at start.
- `base_addr` in ADDR_W: address of pixel (0,0). Sampled at start.
- `mem_rd_en` out 1: read strobe.
- `mem_addr` out ADDR_W: read address, equal to base + row*width + col.
- `mem_rdata` in 16: read data, valid the cycle after `mem_rd_en`. Only bits [3:0] are used.
- `shift_en` out 1: one-cycle shift strobe to the sample shift register.
- `col_out` out 16: column word. [3:0] = row r, [7:4] = row r+1, [11:8] = row r+2, [15:12] = 0.
- `sample_valid` out 1: the window in the shift register is complete.
- `sample_ready` in 1: downstream accepts the window.
- `win_row` out 5: top-left row of the current window.
- `win_col` out 5: top-left column of the current window.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a frame.

## Operation
- States: IDLE, RD0, RD1, RD2, CAP, SHIFT, HOLD, DONE.
- Counters: `row` r (band top), `col` c. Both clear on start.
- IDLE
  - `start`=1 with legal dims: latch inputs, go to RD0.
  - `start`=1 with illegal dims (either dimension <3 or >16): go to DONE. No reads are issued.
  - Otherwise stay in IDLE.
- RD0/RD1/RD2: assert `mem_rd_en`, with `mem_addr` at rows r, r+1, r+2 respectively, column c.
  - RD1, RD2 and CAP each capture `mem_rdata[3:0]` from the previous cycle's read into the pixel slot for rows r, r+1, r+2.
- CAP: after the row r+2 capture, load the assembled word into `col_out` (registered). Go to SHIFT.
- SHIFT: `shift_en`=1 for exactly this cycle.
  - c>=2: go to HOLD.
  - c<2: advance.
- HOLD: `sample_valid`=1. `win_row`=r, `win_col`=c-2.
  - Stay in HOLD while `sample_ready`=0. No shifts and no reads occur while held.
  - When `sample_ready`=1, advance.
- Advance rule:
  - If c<width-1: c++, go to RD0.
  - Else if r<height-3: r++, c=0, go to RD0. The new band refills the shift register, so the first two columns of each band produce no sample.
  - Else go to DONE.
- DONE: `done`=1, then go to IDLE.
- Samples per frame = (W-2)*(H-2). Reads per frame = 3*W*(H-2).
- `start` is ignored in every state other than IDLE.
- Reset (at any time, including mid-frame): the block returns to IDLE immediately. There is no pending read or shift, and no `done` is produced for the aborted frame.

## Timing
- Reset values: all outputs 0, including `col_out`=0, `win_row`=0 and `win_col`=0. State is IDLE.
- Each column takes 5 cycles (RD0..SHIFT), plus HOLD cycles when a sample is pending.
- Cycle numbering below uses `start` sampled at edge 0.
- 3x3 image:
  - RD0 at cycle 1.
  - SHIFT at cycles 5, 10 and 15.
  - `sample_valid` at 16, with `sample_ready` held high.
  - `done` at 17, `busy`=0 at 18.
- `sample_valid` deasserts the cycle after a handshake cycle.
- `sample_ready` has no effect outside HOLD.
- `shift_en` never asserts during HOLD.
- `col_out` holds its value until the next CAP.

## Configuration
- `CONV_COL_FEEDER_CNT_EN` defined:
  - Adds an output port `sample_count` (16 bits, reset 0).
  - The count clears on an accepted `start` and increments on each accepted HOLD handshake.
  - The count holds after `done`.
- `CONV_COL_FEEDER_CNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- 3x3 image, base 0x10, pixel value = address[3:0], ready tied high:
  - Nine reads at 0x10,0x13,0x16, 0x11,0x14,0x17, 0x12,0x15,0x18.
  - Three shifts with `col_out`=0x0630, 0x0741, 0x0852.
  - One `sample_valid` at cycle 16 with win (0,0).
  - `done` at 17.
- 4x4 image, ready high:
  - Four samples with win (0,0), (0,1), (1,0), (1,1).
  - 24 reads.
  - 8 shifts.
- 3x3 image, `sample_ready` low for 5 cycles:
  - `sample_valid` held for 6 cycles, with no reads or shifts meanwhile.
  - `done` 1 cycle after ready rises.
- `img_width`=2: `done` pulses at cycle 1 with zero `mem_rd_en`. Repeat with `img_height`=17 and expect the same.
- `start` pulsed during a 4x4 frame: no effect on the ongoing frame. Then `n_rst` low at cycle 12: all outputs 0, IDLE, no `done`.
- With `CONV_COL_FEEDER_CNT_EN` defined: after a 5x4 frame, `sample_count`=6. The count clears on the next start.
